// File: rtl/pc_sequencer.sv
// Program counter with a hardware return-address stack.
// Supports increment, absolute/relative load, call and return.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] RESET_VEC = 'h2000,
  parameter int unsigned STACK_DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pc_increment,
  input  logic              rel_mode,
  input  logic              call,
  input  logic              ret,
  input  logic              clear_err,
  input  logic [ADDR_W-1:0] address_in,
  output logic [ADDR_W-1:0] address_out,
  output logic [CNT_W-1:0]  stack_count,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_oerr;
  logic              r_uerr;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_inc;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_push;

  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_inc    = r_pc + ADDR_W'(1);
  assign w_tgt    = rel_mode ? (r_pc + address_in) : address_in;
  assign w_wr_idx = PTR_W'(r_cnt);
  assign w_rd_idx = PTR_W'(r_cnt - CNT_W'(1));
  assign w_push   = !ret && call && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_VEC;
      r_cnt  <= '0;
      r_oerr <= 1'b0;
      r_uerr <= 1'b0;
    end else begin
      // clear first so a same-cycle fault below wins
      if (clear_err) begin
        r_oerr <= 1'b0;
        r_uerr <= 1'b0;
      end
      if (ret) begin
        if (!w_empty) begin
          r_pc  <= r_stack[w_rd_idx];
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_uerr <= 1'b1;
        end
      end else if (call) begin
        if (!w_full) begin
          r_pc  <= w_tgt;
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_oerr <= 1'b1;
        end
      end else if (enable) begin
        r_pc <= w_tgt;
      end else if (pc_increment) begin
        r_pc <= w_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_wr_idx] <= w_inc;
    end
  end

  assign address_out   = r_pc;
  assign stack_count   = r_cnt;
  assign stack_full    = w_full;
  assign stack_empty   = w_empty;
  assign overflow_err  = r_oerr;
  assign underflow_err = r_uerr;

endmodule
